// File: rtl/noise_arbiter.sv
// noise_arbiter: shares one 16-bit LCG noise generator among NREQ requesters.
// Round-robin arbitration; optional burst locking when NOISE_ARB_LOCK_EN is defined.
//
// Parameters:
//   NREQ      - number of requesters (2..8)
//   SEED      - generator state loaded on reset
//   MAX_BURST - longest locked burst for one owner (1..15)
// Ports:
//   clk, rst_n   - clock and synchronous active-low reset
//   req [NREQ]   - level request, one byte wanted per cycle
//   lock [NREQ]  - burst hold, ignored unless NOISE_ARB_LOCK_EN is defined
//   seed_we/seed - reseed strobe and value; wins over all requests
//   gnt [NREQ]   - registered one-hot grant
//   rnd_data [8] - registered noise byte, valid while gnt is non-zero
//   busy         - high while a locked burst owns the generator
module noise_arbiter #(
    parameter int          NREQ      = 4,
    parameter logic [15:0] SEED      = 16'd4356,
    parameter int          MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    input  logic            seed_we,
    input  logic [15:0]     seed,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      rnd_data,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RR,
        LOCKED
    } fsm_t;

    fsm_t            fsm;
    logic [15:0]     state;
    logic [PW-1:0]   ptr;

    logic [NREQ-1:0] rr_req;
    logic [PW-1:0]   rr_base;
    logic [NREQ-1:0] rr_oh;
    logic [PW-1:0]   rr_idx;
    logic            rr_vld;

    function automatic logic [7:0] permute(input logic [15:0] s);
        logic [3:0]  sh;
        logic [15:0] x;
        logic [15:0] p;
        sh = {1'b0, s[15:13]} + 4'd3;
        x  = (s >> sh) ^ s;
        p  = x * 16'd62169;
        return p[15:8];
    endfunction

    function automatic logic [15:0] lcg(input logic [15:0] s);
        return s * 16'd12829 + 16'd47989;
    endfunction

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    assign busy = (fsm == LOCKED);

`ifdef NOISE_ARB_LOCK_EN
    localparam logic [3:0] MB = 4'(MAX_BURST);

    logic [PW-1:0]   owner;
    logic [3:0]      cnt;
    logic [NREQ-1:0] own_oh;
    logic            hold;

    // While locked, the owner keeps the generator; on exit the search
    // restarts just past the owner and skips it for that one cycle.
    always_comb begin
        rr_base       = ptr;
        rr_req        = req;
        own_oh        = '0;
        own_oh[owner] = 1'b1;
        hold          = 1'b0;
        if (fsm == LOCKED) begin
            if (req[owner] && lock[owner] && cnt < MB) begin
                hold = 1'b1;
            end else begin
                rr_base = inc_ptr(owner);
                rr_req  = req & ~own_oh;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;

    always_comb begin
        rr_base = ptr;
        rr_req  = req;
    end
`endif

    // Walk from the far end back toward rr_base so the nearest hit wins.
    always_comb begin
        logic [PW-1:0] j;
        rr_oh  = '0;
        rr_idx = '0;
        rr_vld = 1'b0;
        j      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = PW'((int'(rr_base) + k) % NREQ);
            if (rr_req[j]) begin
                rr_oh    = '0;
                rr_oh[j] = 1'b1;
                rr_idx   = j;
                rr_vld   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SEED;
            gnt      <= '0;
            rnd_data <= 8'h00;
            ptr      <= '0;
            fsm      <= IDLE;
`ifdef NOISE_ARB_LOCK_EN
            owner    <= '0;
            cnt      <= '0;
`endif
        end else if (seed_we) begin
            state <= seed;
            gnt   <= '0;
            fsm   <= IDLE;
`ifdef NOISE_ARB_LOCK_EN
            cnt   <= '0;
`endif
`ifdef NOISE_ARB_LOCK_EN
        end else if (hold) begin
            gnt      <= own_oh;
            rnd_data <= permute(state);
            state    <= lcg(state);
            ptr      <= inc_ptr(owner);
            cnt      <= cnt + 4'd1;
`endif
        end else if (rr_vld) begin
            gnt      <= rr_oh;
            rnd_data <= permute(state);
            state    <= lcg(state);
            ptr      <= inc_ptr(rr_idx);
`ifdef NOISE_ARB_LOCK_EN
            if (lock[rr_idx]) begin
                fsm   <= LOCKED;
                owner <= rr_idx;
                cnt   <= 4'd1;
            end else begin
                fsm   <= RR;
                cnt   <= '0;
            end
`else
            fsm      <= RR;
`endif
        end else begin
            gnt <= '0;
            fsm <= IDLE;
`ifdef NOISE_ARB_LOCK_EN
            cnt <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_noise_arbiter.sv
// tb_noise_arbiter: scoreboard bench for noise_arbiter (NREQ=4, default SEED).
// Stimulus queues expected grants; a monitor checks every granting cycle.
module tb_noise_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic        seed_we;
    logic [15:0] seed;
    logic [3:0]  gnt;
    logic [7:0]  rnd_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
        logic       b;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ms;

    noise_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .seed_we  (seed_we),
        .seed     (seed),
        .gnt      (gnt),
        .rnd_data (rnd_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_perm(input logic [15:0] s);
        int          sh;
        logic [15:0] x;
        logic [31:0] p;
        sh = int'(s[15:13]) + 3;
        x  = (s >> sh) ^ s;
        p  = {16'h0, x} * 32'd62169;
        return p[15:8];
    endfunction

    function automatic logic [15:0] ref_lcg(input logic [15:0] s);
        logic [31:0] n;
        n = {16'h0, s} * 32'd12829 + 32'd47989;
        return n[15:0];
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic step(input logic rn, input logic [3:0] r,
                        input logic [3:0] l, input logic sw,
                        input logic [15:0] sd);
        @(negedge clk);
        rst_n   = rn;
        req     = r;
        lock    = l;
        seed_we = sw;
        seed    = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [3:0] r);
        step(1'b1, r, 4'b0000, 1'b0, 16'h0);
    endtask

    task automatic exp_c(input logic [3:0] g, input logic [7:0] d,
                         input logic b);
        sb.push_back('{g: g, d: d, b: b});
        ms = ref_lcg(ms);
    endtask

    task automatic exp_m(input logic [3:0] g, input logic b);
        sb.push_back('{g: g, d: ref_perm(ms), b: b});
        ms = ref_lcg(ms);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_gnt"}, {12'h0, gnt}, 16'h0);
    endtask

    // Monitor: every granting cycle must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (gnt !== 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_gnt", {12'h0, gnt}, 16'h0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_gnt", {12'h0, gnt}, {12'h0, e.g});
                    chk("sb_data", {8'h0, rnd_data}, {8'h0, e.d});
                    chk("sb_busy", {15'h0, busy}, {15'h0, e.b});
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        lock    = '0;
        seed_we = 1'b0;
        seed    = '0;
        ms      = 16'd4356;

        step(1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0);
        chk("rst_gnt", {12'h0, gnt}, 16'h0);
        chk("rst_data", {8'h0, rnd_data}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        go(4'b0000);
        chk_idle("post_release");

        // Sole requester: one byte every cycle.
        exp_c(4'b0001, 8'h41, 1'b0);
        go(4'b0001);
        exp_c(4'b0001, 8'hA0, 1'b0);
        go(4'b0001);
        go(4'b0000);
        chk_idle("no_req");
        chk("no_req_hold", {8'h0, rnd_data}, 16'h00A0);

        // All request: rotating grants with wrap.
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0);
        ms = 16'd4356;
        for (int i = 0; i < 8; i++) begin
            exp_m(4'b0001 << (i % 4), 1'b0);
            go(4'b1111);
        end
        go(4'b0000);

        // Pointer position and skipping idle requesters.
        exp_m(4'b0100, 1'b0);
        go(4'b0100);
        exp_m(4'b0001, 1'b0);
        go(4'b0011);
        exp_m(4'b1000, 1'b0);
        go(4'b1001);
        exp_m(4'b0010, 1'b0);
        go(4'b0110);

        // Reseed blocks the grant that cycle.
        step(1'b1, 4'b0010, 4'b0000, 1'b1, 16'd4356);
        chk_idle("seed_cycle");
        ms = 16'd4356;
        exp_c(4'b0010, 8'h41, 1'b0);
        go(4'b0010);
        step(1'b1, 4'b1111, 4'b0000, 1'b1, 16'h0000);
        chk_idle("seed_zero_cycle");
        ms = 16'h0000;
        exp_c(4'b0001, 8'h00, 1'b0);
        go(4'b0001);

        // Reset beats reseed.
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 16'h0000);
        chk_idle("rst_seed");
        ms = 16'd4356;
        exp_c(4'b0001, 8'h41, 1'b0);
        go(4'b0001);

        // Reset mid-stream abandons it.
        exp_m(4'b0010, 1'b0);
        go(4'b1111);
        exp_m(4'b0100, 1'b0);
        go(4'b1111);
        step(1'b0, 4'b1111, 4'b0000, 1'b0, 16'h0);
        chk_idle("mid_rst");
        chk("mid_rst_data", {8'h0, rnd_data}, 16'h0);
        go(4'b0000);
        chk_idle("mid_rst_release");
        ms = 16'd4356;
        exp_c(4'b0001, 8'h41, 1'b0);
        go(4'b0001);

`ifdef NOISE_ARB_LOCK_EN
        // Burst of MAX_BURST to requester 2, then round-robin resumes.
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0);
        ms = 16'd4356;
        exp_m(4'b0001, 1'b0);
        exp_m(4'b0010, 1'b0);
        exp_m(4'b0100, 1'b1);
        exp_m(4'b0100, 1'b1);
        exp_m(4'b0100, 1'b1);
        exp_m(4'b0100, 1'b1);
        exp_m(4'b1000, 1'b0);
        exp_m(4'b0001, 1'b0);
        exp_m(4'b0010, 1'b0);
        exp_m(4'b0100, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b1111, 4'b0100, 1'b0, 16'h0);
        end
        step(1'b0, 4'b1111, 4'b0100, 1'b0, 16'h0);
        chk_idle("lock_rst");
        chk("lock_rst_busy", {15'h0, busy}, 16'h0);
        chk("lock_rst_data", {8'h0, rnd_data}, 16'h0);
        ms = 16'd4356;
        exp_c(4'b0001, 8'h41, 1'b0);
        step(1'b1, 4'b0001, 4'b0000, 1'b0, 16'h0);
`else
        // Lock is ignored: plain rotation, never busy.
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 16'h0);
        ms = 16'd4356;
        for (int i = 0; i < 5; i++) begin
            exp_m(4'b0001 << (i % 4), 1'b0);
            step(1'b1, 4'b1111, 4'b1111, 1'b0, 16'h0);
        end
`endif

        go(4'b0000);
        chk_idle("final_idle");
        go(4'b0000);
        chk("sb_empty", 16'(sb.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
